// File: rtl/sae_core.sv
// sae_core: single-cycle affine (mod 26) ASCII cipher with key/character validation.
// Optional build macro: SAE_SPACE_PASSTHRU_EN (space 0x20 passes through unchanged).
`default_nettype none

module sae_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode,
    input  logic [7:0]  data_input,
    input  logic [15:0] key_input,
    input  logic        inputs_valid,
    output logic [7:0]  data_output,
    output logic        output_ready,
    output logic        err_invalid_ptxt_char,
    output logic        err_invalid_seckey,
    output logic        err_invalid_ctxt_char
);

    localparam logic [7:0]  PTXT_BASE = 8'h61;
    localparam logic [7:0]  PTXT_LAST = 8'h7A;
    localparam logic [7:0]  CTXT_BASE = 8'h41;
    localparam logic [7:0]  CTXT_LAST = 8'h5A;
    localparam logic [7:0]  SPACE     = 8'h20;
    localparam logic [11:0] MODULUS   = 12'd26;

    logic [7:0]  k1;
    logic [7:0]  k2;
    logic [4:0]  k1_inv;
    logic        k1_ok;
    logic        key_err;
    logic        is_space;
    logic        ptxt_err;
    logic        ctxt_err;
    logic [4:0]  idx;
    logic [11:0] enc_full;
    logic [11:0] dec_full;
    logic [4:0]  enc_idx;
    logic [4:0]  dec_idx;
    logic [7:0]  result;

    always_comb begin
        k1     = key_input[15:8];
        k2     = key_input[7:0];
        k1_inv = 5'd0;
        k1_ok  = 1'b1;
        case (k1)
            8'd1:    k1_inv = 5'd1;
            8'd3:    k1_inv = 5'd9;
            8'd5:    k1_inv = 5'd21;
            8'd7:    k1_inv = 5'd15;
            8'd9:    k1_inv = 5'd3;
            8'd11:   k1_inv = 5'd19;
            8'd15:   k1_inv = 5'd7;
            8'd17:   k1_inv = 5'd23;
            8'd19:   k1_inv = 5'd11;
            8'd21:   k1_inv = 5'd5;
            8'd23:   k1_inv = 5'd17;
            8'd25:   k1_inv = 5'd25;
            default: k1_ok  = 1'b0;
        endcase
        key_err = !k1_ok || (k2 > 8'd25);
    end

    always_comb begin
`ifdef SAE_SPACE_PASSTHRU_EN
        is_space = (data_input == SPACE);
`else
        is_space = 1'b0;
`endif
        ptxt_err = !mode && !is_space &&
                   !((data_input >= PTXT_BASE) && (data_input <= PTXT_LAST));
        ctxt_err = mode && !is_space &&
                   !((data_input >= CTXT_BASE) && (data_input <= CTXT_LAST));
    end

    // Index and arithmetic are only meaningful when both checks pass; the
    // output mux below zeroes the result otherwise.
    always_comb begin
        idx      = mode ? 5'(data_input - CTXT_BASE) : 5'(data_input - PTXT_BASE);
        enc_full = 12'(k1[4:0]) * 12'(idx) + 12'(k2[4:0]);
        dec_full = 12'(k1_inv) * (12'(idx) + MODULUS - 12'(k2[4:0]));
        enc_idx  = 5'(enc_full % MODULUS);
        dec_idx  = 5'(dec_full % MODULUS);

        if (key_err || ptxt_err || ctxt_err) begin
            result = 8'h00;
        end else if (is_space) begin
            result = SPACE;
        end else if (mode) begin
            result = PTXT_BASE + 8'(dec_idx);
        end else begin
            result = CTXT_BASE + 8'(enc_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_output           <= 8'h00;
            output_ready          <= 1'b0;
            err_invalid_ptxt_char <= 1'b0;
            err_invalid_seckey    <= 1'b0;
            err_invalid_ctxt_char <= 1'b0;
        end else begin
            output_ready <= inputs_valid;
            if (inputs_valid) begin
                data_output           <= result;
                err_invalid_ptxt_char <= ptxt_err;
                err_invalid_seckey    <= key_err;
                err_invalid_ctxt_char <= ctxt_err;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sae_core.sv
// tb_sae_core: randomized scoreboard bench for sae_core against an arithmetic reference model.
`default_nettype none

module tb_sae_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  data_input = 8'h00;
    logic [15:0] key_input = 16'h0000;
    logic        inputs_valid = 1'b0;
    logic [7:0]  data_output;
    logic        output_ready;
    logic        err_invalid_ptxt_char;
    logic        err_invalid_seckey;
    logic        err_invalid_ctxt_char;

    typedef struct packed {
        logic [7:0] d;
        logic       ep;
        logic       ek;
        logic       ec;
    } res_t;

    res_t sb[$];
    res_t last_res = '0;
    int   n_cmp = 0;
    int   n_bad = 0;

    sae_core dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .mode                  (mode),
        .data_input            (data_input),
        .key_input             (key_input),
        .inputs_valid          (inputs_valid),
        .data_output           (data_output),
        .output_ready          (output_ready),
        .err_invalid_ptxt_char (err_invalid_ptxt_char),
        .err_invalid_seckey    (err_invalid_seckey),
        .err_invalid_ctxt_char (err_invalid_ctxt_char)
    );

    always #5 clk = ~clk;

    function automatic int gcd(input int a, input int b);
        int x = a;
        int y = b;
        while (y != 0) begin
            int t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Decryption is done by searching for the plaintext that encrypts to C,
    // so the model never needs an inverse table.
    function automatic res_t model(input logic m, input logic [7:0] d, input logic [15:0] key);
        res_t r;
        int k1 = int'(key[15:8]);
        int k2 = int'(key[7:0]);
        int di = int'(d);
        bit sp = 1'b0;
`ifdef SAE_SPACE_PASSTHRU_EN
        sp = (di == 32);
`endif
        r    = '0;
        r.ek = !(k1 < 26 && gcd(k1, 26) == 1) || (k2 > 25);
        r.ep = !m && !sp && !(di >= 97 && di <= 122);
        r.ec = m && !sp && !(di >= 65 && di <= 90);
        if (r.ek || r.ep || r.ec)
            r.d = 8'h00;
        else if (sp)
            r.d = 8'h20;
        else if (!m)
            r.d = 8'(65 + (k1 * (di - 97) + k2) % 26);
        else begin
            for (int p = 0; p < 26; p++)
                if ((k1 * p + k2) % 26 == di - 65)
                    r.d = 8'(97 + p);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input res_t e, input logic rdy);
        check({tag, "_ready"}, 32'(output_ready), 32'(rdy));
        check({tag, "_data"}, 32'(data_output), 32'(e.d));
        check({tag, "_err_ptxt"}, 32'(err_invalid_ptxt_char), 32'(e.ep));
        check({tag, "_err_key"}, 32'(err_invalid_seckey), 32'(e.ek));
        check({tag, "_err_ctxt"}, 32'(err_invalid_ctxt_char), 32'(e.ec));
    endtask

    // Monitor: sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            last_res = '0;
            check_outputs("reset", '0, 1'b0);
        end else if (output_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(output_ready), 32'd0);
            end else begin
                last_res = sb.pop_front();
                check_outputs("result", last_res, 1'b1);
            end
        end else begin
            check_outputs("hold", last_res, 1'b0);
        end
    end

    task automatic step(input logic r, input logic v, input logic m,
                        input logic [7:0] d, input logic [15:0] k);
        @(negedge clk);
        rst_n        = r;
        inputs_valid = v;
        mode         = m;
        data_input   = d;
        key_input    = k;
        if (v && r)
            sb.push_back(model(m, d, k));
    endtask

    localparam int NLEGAL = 12;
    int legal_k1 [NLEGAL] = '{1, 3, 5, 7, 9, 11, 15, 17, 19, 21, 23, 25};

    initial begin
        logic        m;
        logic [7:0]  d;
        logic [15:0] k;
        int          sel;

        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        // First request on the first edge with reset released.
        step(1'b1, 1'b1, 1'b0, 8'h61, 16'h0508);
        step(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 8'h68, 16'h0508);
        step(1'b1, 1'b1, 1'b1, 8'h52, 16'h0508);
        step(1'b1, 1'b1, 1'b0, 8'h61, 16'h0408);
        step(1'b1, 1'b1, 1'b0, 8'h61, 16'h051A);
        step(1'b1, 1'b1, 1'b0, 8'h41, 16'h0508);
        step(1'b1, 1'b1, 1'b1, 8'h61, 16'h0508);
        step(1'b1, 1'b1, 1'b1, 8'h61, 16'h0D30);
        step(1'b1, 1'b1, 1'b0, 8'h61, 16'h0508);
        step(1'b1, 1'b1, 1'b0, 8'h62, 16'h0508);
        step(1'b1, 1'b1, 1'b0, 8'h63, 16'h0508);
        step(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 8'h20, 16'h0508);
        step(1'b1, 1'b1, 1'b1, 8'h20, 16'h0508);
        step(1'b1, 1'b1, 1'b0, 8'h20, 16'h0408);
        step(1'b1, 1'b1, 1'b1, 8'h7A, 16'h1919);
        step(1'b1, 1'b1, 1'b1, 8'h5A, 16'h1919);
        // Reset coincident with a valid request: request is dropped.
        step(1'b0, 1'b1, 1'b0, 8'h61, 16'h0508);
        step(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 8'h79, 16'h0101);

        for (int i = 0; i < 400; i++) begin
            m   = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 19));
            if (sel < 14)
                d = m ? 8'(65 + $urandom_range(0, 25)) : 8'(97 + $urandom_range(0, 25));
            else if (sel == 14)
                d = 8'h20;
            else
                d = 8'($urandom);
            if ($urandom_range(0, 4) != 0)
                k = {8'(legal_k1[$urandom_range(0, NLEGAL - 1)]), 8'($urandom_range(0, 25))};
            else
                k = 16'($urandom);
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), m, d, k);
        end

        repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
